icache_refill_ctrl: RTL and testbench

- Sequences the fetch-stage instruction cache port: services misses by bursting one 8-word line from the memory bus, then writes it into the cache.
- Also schedules full and selective invalidations, e.g. for fence.i or satp changes.
- Sits between the fetch stage cache port and the shared memory read port. Holds the pipeline while any operation is outstanding.

---
 rtl/icache_refill_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// Instruction cache refill/invalidate sequencer: bursts an 8-word line from the
// memory read port into the fetch-stage cache port and schedules invalidations.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting; pending invalidate beats a new miss
//   S_INVAL | cache_invalidate held until the pipeline is not stalled
//   S_REQ   | burst request held until the memory accepts it
//   S_BEAT  | collecting beats into the line buffer, watchdog running
//   S_WRITE | cache_port_set held until the pipeline is not stalled
//   S_DRAIN | swallowing the rest of a failed burst, no write
module icache_refill_ctrl #(
    parameter int VLEN           = 39,
    parameter int PLEN           = 34,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 miss,
    input  logic [VLEN-6:0]      miss_vaddr,
    input  logic [PLEN-6:0]      miss_paddr,
    input  logic                 abort,
    input  logic                 inval_req,
    input  logic                 inval_selective,
    input  logic                 inval_top,
    input  logic                 pipe_stall,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [PLEN-1:0]      mem_req_addr,
    input  logic                 mem_resp_valid,
    input  logic [31:0]          mem_resp_data,
    input  logic                 mem_resp_error,
    output logic [VLEN-6:0]      cache_port_addr,
    output logic [7:0][31:0]     cache_port_data,
    output logic                 cache_port_set,
    output logic                 cache_invalidate,
    output logic                 selective_invalidate,
    output logic                 selective_invalidate_vaddr,
    output logic                 refill_busy,
    output logic                 refill_fault
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INVAL, S_REQ, S_BEAT, S_WRITE, S_DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic [VLEN-6:0]   vaddr_q, vaddr_d;
    logic [PLEN-6:0]   paddr_q, paddr_d;
    logic [7:0][31:0]  data_q, data_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic              abort_q, abort_d;
    logic              fault_q, fault_d;
    logic              inv_sel_q, inv_sel_d;
    logic              inv_top_q, inv_top_d;
    logic              pend_q, pend_d;
    logic              pend_sel_q, pend_sel_d;
    logic              pend_top_q, pend_top_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            vaddr_q    <= '0;
            paddr_q    <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            abort_q    <= 1'b0;
            fault_q    <= 1'b0;
            inv_sel_q  <= 1'b0;
            inv_top_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_sel_q <= 1'b0;
            pend_top_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vaddr_q    <= vaddr_d;
            paddr_q    <= paddr_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            abort_q    <= abort_d;
            fault_q    <= fault_d;
            inv_sel_q  <= inv_sel_d;
            inv_top_q  <= inv_top_d;
            pend_q     <= pend_d;
            pend_sel_q <= pend_sel_d;
            pend_top_q <= pend_top_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vaddr_d    = vaddr_q;
        paddr_d    = paddr_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        abort_d    = abort_q;
        fault_d    = 1'b0;
        inv_sel_d  = inv_sel_q;
        inv_top_d  = inv_top_q;
        pend_d     = pend_q;
        pend_sel_d = pend_sel_q;
        pend_top_d = pend_top_q;

        // A second request while one is queued widens it to a full invalidate.
        if (inval_req && state_q != S_IDLE) begin
            pend_d = 1'b1;
            if (pend_q) begin
                pend_sel_d = 1'b0;
                pend_top_d = 1'b0;
            end else begin
                pend_sel_d = inval_selective;
                pend_top_d = inval_top;
            end
        end

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (pend_q) begin
                    state_d   = S_INVAL;
                    pend_d    = 1'b0;
                    inv_sel_d = inval_req ? 1'b0 : pend_sel_q;
                    inv_top_d = inval_req ? 1'b0 : pend_top_q;
                end else if (inval_req) begin
                    state_d   = S_INVAL;
                    inv_sel_d = inval_selective;
                    inv_top_d = inval_top;
                end else if (miss) begin
                    state_d = S_REQ;
                    vaddr_d = miss_vaddr;
                    paddr_d = miss_paddr;
                end
            end
            S_INVAL: begin
                if (!pipe_stall) state_d = S_IDLE;
            end
            S_REQ: begin
                if (abort) abort_d = 1'b1;
                if (mem_req_ready) begin
                    state_d = S_BEAT;
                    cnt_d   = 3'd0;
                    tmr_d   = TMR_LOAD;
                end
            end
            S_BEAT: begin
                if (abort) abort_d = 1'b1;
                if (mem_resp_valid) begin
                    cnt_d = cnt_q + 3'd1;
                    tmr_d = TMR_LOAD;
                    if (mem_resp_error) begin
                        fault_d = 1'b1;
                        state_d = (cnt_q == 3'd7) ? S_IDLE : S_DRAIN;
                    end else begin
                        data_d[cnt_q] = mem_resp_data;
                        if (cnt_q == 3'd7) state_d = (abort_q || abort) ? S_IDLE : S_WRITE;
                    end
                end else if (tmr_q == '0) begin
                    fault_d = 1'b1;
                    state_d = S_DRAIN;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_WRITE: begin
                if (!pipe_stall) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (mem_resp_valid) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req_valid              = (state_q == S_REQ);
    assign mem_req_addr               = {paddr_q, 5'b0};
    assign cache_port_addr            = vaddr_q;
    assign cache_port_data            = data_q;
    assign cache_port_set             = (state_q == S_WRITE);
    assign cache_invalidate           = (state_q == S_INVAL);
    assign selective_invalidate       = cache_invalidate & inv_sel_q;
    assign selective_invalidate_vaddr = cache_invalidate & inv_top_q;
    assign refill_busy                = (state_q != S_IDLE);
    assign refill_fault               = fault_q;

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Self-checking bench for icache_refill_ctrl: scenario tasks driving a bus model
// and comparing against expectations derived from line/beat arithmetic.
module tb_icache_refill_ctrl;

    localparam int VLEN = 39;
    localparam int PLEN = 34;
    localparam int TMO  = 1024;

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 miss = 1'b0;
    logic [VLEN-6:0]      miss_vaddr = '0;
    logic [PLEN-6:0]      miss_paddr = '0;
    logic                 abort = 1'b0;
    logic                 inval_req = 1'b0;
    logic                 inval_selective = 1'b0;
    logic                 inval_top = 1'b0;
    logic                 pipe_stall = 1'b0;
    logic                 mem_req_valid;
    logic                 mem_req_ready = 1'b0;
    logic [PLEN-1:0]      mem_req_addr;
    logic                 mem_resp_valid = 1'b0;
    logic [31:0]          mem_resp_data = '0;
    logic                 mem_resp_error = 1'b0;
    logic [VLEN-6:0]      cache_port_addr;
    logic [7:0][31:0]     cache_port_data;
    logic                 cache_port_set;
    logic                 cache_invalidate;
    logic                 selective_invalidate;
    logic                 selective_invalidate_vaddr;
    logic                 refill_busy;
    logic                 refill_fault;

    icache_refill_ctrl #(.VLEN(VLEN), .PLEN(PLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset_n(reset_n), .miss(miss), .miss_vaddr(miss_vaddr),
        .miss_paddr(miss_paddr), .abort(abort), .inval_req(inval_req),
        .inval_selective(inval_selective), .inval_top(inval_top), .pipe_stall(pipe_stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .mem_resp_error(mem_resp_error), .cache_port_addr(cache_port_addr),
        .cache_port_data(cache_port_data), .cache_port_set(cache_port_set),
        .cache_invalidate(cache_invalidate), .selective_invalidate(selective_invalidate),
        .selective_invalidate_vaddr(selective_invalidate_vaddr), .refill_busy(refill_busy),
        .refill_fault(refill_fault)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0]      beat_data [8];
    int               r_commits, r_set_cycles, r_commit_cycle, r_last_beat, r_end_cycle;
    int               r_faults, r_fault_cycle, r_hs_cycle;
    logic [PLEN-1:0]  r_req_addr;
    logic [VLEN-6:0]  r_commit_addr;
    logic [7:0][31:0] r_commit_data;
    bit               r_unstable, r_both, r_req_bad, r_expired;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Bus/pipeline model for one miss; records what the DUT did, checks nothing.
    task automatic run_refill(input logic [VLEN-6:0] va, input logic [PLEN-6:0] pa,
                              input int ready_dly, input int first_gap, input int gap_pct,
                              input int abort_at, input int err_at, input int stall_n,
                              input int inval_at, input int inval2_at, input bit noise);
        int beats = 0, req_wait = 0, idle_wait = 0, post = 0;
        bit hs = 0, req_seen = 0, abort_done = 0, inv1_done = 0, inv2_done = 0, beat_now;
        r_commits = 0; r_set_cycles = 0; r_commit_cycle = -1; r_last_beat = -1;
        r_end_cycle = -1; r_faults = 0; r_fault_cycle = -1; r_hs_cycle = -1;
        r_req_addr = '0; r_commit_addr = '0; r_commit_data = '0;
        r_unstable = 0; r_both = 0; r_req_bad = 0; r_expired = 1;
        miss = 1'b1; miss_vaddr = va; miss_paddr = pa;
        @(negedge clock);
        tick();
        miss = 1'b0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            mem_req_ready = !hs && (req_wait >= ready_dly);
            mem_resp_valid = 1'b0; mem_resp_error = 1'b0; mem_resp_data = $urandom;
            abort = 1'b0; inval_req = 1'b0; miss = 1'b0; beat_now = 0;
            if (hs && beats < 8) begin
                if (beats == 0 && idle_wait < first_gap) idle_wait++;
                else if (int'($urandom_range(99)) >= gap_pct) begin
                    beat_now = 1;
                    mem_resp_valid = 1'b1;
                    mem_resp_data = beat_data[beats];
                    mem_resp_error = (beats == err_at);
                end
                if (abort_at >= 0 && beats == abort_at && !abort_done) begin
                    abort = 1'b1; abort_done = 1;
                end
                if (beat_now && beats == inval_at && !inv1_done) begin
                    inval_req = 1'b1; inval_selective = 1'b1; inval_top = 1'b1; inv1_done = 1;
                end else if (beat_now && beats == inval2_at && !inv2_done) begin
                    inval_req = 1'b1; inval_selective = 1'b1; inval_top = 1'b0; inv2_done = 1;
                end
                if (noise) begin
                    miss = 1'($urandom_range(1));
                    miss_vaddr = {$urandom, 2'b0};
                    miss_paddr = $urandom;
                end
            end
            if (beats == 8) begin
                pipe_stall = (post < stall_n);
                post++;
            end else begin
                pipe_stall = 1'($urandom_range(1));
            end
            @(negedge clock);
            if (!hs) begin
                if (mem_req_valid) begin
                    if (!req_seen) r_req_addr = mem_req_addr;
                    else if (mem_req_addr !== r_req_addr) r_req_bad = 1;
                    req_seen = 1;
                    if (mem_req_ready) begin hs = 1; r_hs_cycle = cyc; end
                    else req_wait++;
                end else if (req_seen) r_req_bad = 1;
            end
            if (beat_now) begin beats++; r_last_beat = cyc; end
            if (cache_port_set) begin
                if (r_set_cycles == 0) begin
                    r_commit_addr = cache_port_addr; r_commit_data = cache_port_data;
                end else if (cache_port_addr !== r_commit_addr || cache_port_data !== r_commit_data)
                    r_unstable = 1;
                r_set_cycles++;
                if (!pipe_stall) begin r_commits++; r_commit_cycle = cyc; end
            end
            if (cache_port_set && cache_invalidate) r_both = 1;
            if (refill_fault) begin r_faults++; r_fault_cycle = cyc; end
            if (!refill_busy) begin r_end_cycle = cyc; r_expired = 0; end
            tick();
            if (!r_expired) break;
        end
        miss = 1'b0; abort = 1'b0; inval_req = 1'b0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_resp_error = 1'b0; pipe_stall = 1'b0;
        if (r_expired) begin
            n_cmp++; n_fail++;
            $display("FAIL refill_budget: busy never dropped within 3000 cycles");
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_cmp++;
        if ({mem_req_valid, cache_port_set, cache_invalidate, selective_invalidate,
             selective_invalidate_vaddr, refill_busy, refill_fault} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 0000000", {mem_req_valid, cache_port_set,
                     cache_invalidate, selective_invalidate, selective_invalidate_vaddr,
                     refill_busy, refill_fault});
        end
        n_cmp++;
        if (cache_port_data !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", cache_port_data);
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_refill();
        for (int i = 0; i < 8; i++) beat_data[i] = 32'h13 + 32'(4 * i);
        run_refill(34'h123, 29'h40, 0, 0, 0, -1, -1, 0, -1, -1, 0);
        n_cmp++;
        if (r_req_addr !== 34'h800) begin
            n_fail++; $display("FAIL basic_req_addr: got %h want 800", r_req_addr);
        end
        n_cmp++;
        if (r_commit_cycle !== 10 || r_set_cycles !== 1 || r_commits !== 1) begin
            n_fail++;
            $display("FAIL basic_commit: cycle %0d sets %0d commits %0d want 10/1/1",
                     r_commit_cycle, r_set_cycles, r_commits);
        end
        n_cmp++;
        if (r_commit_addr !== 34'h123) begin
            n_fail++; $display("FAIL basic_addr: got %h want 123", r_commit_addr);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (r_commit_data[i] !== beat_data[i]) begin
                n_fail++;
                $display("FAIL basic_word%0d: got %h want %h", i, r_commit_data[i], beat_data[i]);
            end
        end
        n_cmp++;
        if (r_end_cycle !== 11 || r_faults !== 0) begin
            n_fail++;
            $display("FAIL basic_busy_fall: end %0d faults %0d want 11/0", r_end_cycle, r_faults);
        end
    endtask

    task automatic test_stall_hold();
        for (int i = 0; i < 8; i++) beat_data[i] = $urandom;
        run_refill(34'h2_0000_0abc, 29'h1ff_0001, 1, 2, 0, -1, -1, 3, -1, -1, 0);
        n_cmp++;
        if (r_set_cycles !== 4 || r_commits !== 1 || r_unstable) begin
            n_fail++;
            $display("FAIL stall_hold: sets %0d commits %0d unstable %0d want 4/1/0",
                     r_set_cycles, r_commits, r_unstable);
        end
        n_cmp++;
        if (r_commit_cycle !== r_last_beat + 4 || r_commit_data[7] !== beat_data[7]) begin
            n_fail++;
            $display("FAIL stall_commit: cycle %0d want %0d word7 %h want %h",
                     r_commit_cycle, r_last_beat + 4, r_commit_data[7], beat_data[7]);
        end
        n_cmp++;
        if (r_req_addr !== {29'h1ff_0001, 5'b0} || r_req_bad) begin
            n_fail++; $display("FAIL stall_req: addr %h bad %0d", r_req_addr, r_req_bad);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 8; i++) beat_data[i] = $urandom;
        run_refill(34'h55, 29'h77, 0, 0, 0, 4, -1, 0, -1, -1, 0);
        n_cmp++;
        if (r_set_cycles !== 0 || r_end_cycle !== r_last_beat + 1) begin
            n_fail++;
            $display("FAIL abort: sets %0d end %0d want 0/%0d", r_set_cycles, r_end_cycle,
                     r_last_beat + 1);
        end
    endtask

    task automatic test_bus_error();
        for (int i = 0; i < 8; i++) beat_data[i] = $urandom;
        run_refill(34'h99, 29'h33, 0, 0, 20, -1, 2, 0, -1, -1, 0);
        n_cmp++;
        if (r_faults !== 1 || r_set_cycles !== 0 || r_end_cycle !== r_last_beat + 1) begin
            n_fail++;
            $display("FAIL bus_error: faults %0d sets %0d end %0d want 1/0/%0d",
                     r_faults, r_set_cycles, r_end_cycle, r_last_beat + 1);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 8; i++) beat_data[i] = $urandom;
        run_refill(34'h10, 29'h20, 0, TMO + 80, 0, -1, -1, 0, -1, -1, 0);
        n_cmp++;
        if (r_faults !== 1 || r_set_cycles !== 0 || r_end_cycle !== r_last_beat + 1) begin
            n_fail++;
            $display("FAIL timeout: faults %0d sets %0d end %0d want 1/0/%0d",
                     r_faults, r_set_cycles, r_end_cycle, r_last_beat + 1);
        end
        n_cmp++;
        if (!(r_fault_cycle - r_hs_cycle >= TMO && r_fault_cycle - r_hs_cycle <= TMO + 2)) begin
            n_fail++;
            $display("FAIL timeout_when: fault %0d cycles after request, want about %0d",
                     r_fault_cycle - r_hs_cycle, TMO);
        end
    endtask

    task automatic test_inval_during_refill();
        for (int i = 0; i < 8; i++) beat_data[i] = $urandom;
        run_refill(34'h321, 29'h41, 0, 0, 0, -1, -1, 0, 5, -1, 0);
        n_cmp++;
        if (r_commits !== 1 || r_both) begin
            n_fail++; $display("FAIL inval_refill_first: commits %0d both %0d", r_commits, r_both);
        end
        @(negedge clock);
        n_cmp++;
        if ({cache_invalidate, selective_invalidate, selective_invalidate_vaddr} !== 3'b111) begin
            n_fail++;
            $display("FAIL inval_selective: got %b want 111", {cache_invalidate,
                     selective_invalidate, selective_invalidate_vaddr});
        end
        tick(); tick();
        run_refill(34'h322, 29'h42, 0, 0, 0, -1, -1, 0, 5, 6, 0);
        pipe_stall = 1'b1;
        @(negedge clock);
        tick();
        @(negedge clock);
        n_cmp++;
        if ({cache_invalidate, selective_invalidate, cache_port_set} !== 3'b100) begin
            n_fail++;
            $display("FAIL inval_merged_held: got %b want 100", {cache_invalidate,
                     selective_invalidate, cache_port_set});
        end
        pipe_stall = 1'b0;
        tick();
        @(negedge clock);
        n_cmp++;
        if (refill_busy !== 1'b0) begin
            n_fail++; $display("FAIL inval_done: busy %b want 0", refill_busy);
        end
        tick();
    endtask

    task automatic test_inval_idle();
        logic s, t;
        s = 1'($urandom_range(1)); t = 1'($urandom_range(1));
        inval_req = 1'b1; inval_selective = s; inval_top = t;
        miss = 1'b1; miss_vaddr = 34'h7; miss_paddr = 29'h7;
        tick();
        inval_req = 1'b0; miss = 1'b0;
        @(negedge clock);
        n_cmp++;
        if ({cache_invalidate, selective_invalidate, selective_invalidate_vaddr, mem_req_valid}
            !== {1'b1, s, t, 1'b0}) begin
            n_fail++;
            $display("FAIL inval_idle: got %b want %b", {cache_invalidate, selective_invalidate,
                     selective_invalidate_vaddr, mem_req_valid}, {1'b1, s, t, 1'b0});
        end
        tick();
        @(negedge clock);
        n_cmp++;
        if (refill_busy !== 1'b0) begin
            n_fail++; $display("FAIL inval_miss_dropped: busy %b want 0", refill_busy);
        end
        tick();
    endtask

    task automatic test_reset_mid_beat();
        miss = 1'b1; miss_vaddr = 34'h44; miss_paddr = 29'h45;
        tick();
        miss = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = 32'hdead_0000 + 32'(i);
            tick();
        end
        mem_resp_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({refill_busy, mem_req_valid, cache_port_set, cache_invalidate, refill_fault} !== 5'b0
            || cache_port_data !== '0 || mem_req_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_async: flags %b data %h addr %h want all 0", {refill_busy,
                     mem_req_valid, cache_port_set, cache_invalidate, refill_fault},
                     cache_port_data, mem_req_addr);
        end
        mem_resp_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) beat_data[i] = $urandom;
        run_refill(34'h46, 29'h47, 0, 0, 0, -1, -1, 0, -1, -1, 0);
        n_cmp++;
        if (r_commit_cycle !== 10 || r_commit_data[0] !== beat_data[0]
            || r_commit_data[7] !== beat_data[7]) begin
            n_fail++;
            $display("FAIL reset_restart: cycle %0d w0 %h want %h w7 %h want %h", r_commit_cycle,
                     r_commit_data[0], beat_data[0], r_commit_data[7], beat_data[7]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            logic [VLEN-6:0] va;
            logic [PLEN-6:0] pa;
            int ab, er, st;
            bit exp_write;
            va = {$urandom, 2'($urandom_range(3))};
            pa = 29'($urandom);
            ab = ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1;
            er = ($urandom_range(4) == 0) ? int'($urandom_range(7)) : -1;
            st = $urandom_range(3);
            for (int i = 0; i < 8; i++) beat_data[i] = $urandom;
            exp_write = (ab < 0) && (er < 0);
            run_refill(va, pa, $urandom_range(3), $urandom_range(4), 30, ab, er, st, -1, -1, 1);
            n_cmp++;
            if (r_commits !== int'(exp_write) || r_faults !== int'(er >= 0) || r_both
                || r_req_bad || r_req_addr !== {pa, 5'b0}) begin
                n_fail++;
                $display("FAIL rand%0d_ctrl: commits %0d want %0d faults %0d want %0d both %0d reqbad %0d",
                         n, r_commits, exp_write, r_faults, er >= 0, r_both, r_req_bad);
            end
            if (exp_write) begin
                n_cmp++;
                if (r_commit_addr !== va || r_commit_data !== {beat_data[7], beat_data[6],
                    beat_data[5], beat_data[4], beat_data[3], beat_data[2], beat_data[1],
                    beat_data[0]} || r_set_cycles !== st + 1 || r_commit_cycle !== r_last_beat + 1 + st) begin
                    n_fail++;
                    $display("FAIL rand%0d_line: addr %h want %h sets %0d want %0d cycle %0d want %0d",
                             n, r_commit_addr, va, r_set_cycles, st + 1, r_commit_cycle,
                             r_last_beat + 1 + st);
                end
            end else begin
                n_cmp++;
                if (r_set_cycles !== 0 || r_end_cycle !== r_last_beat + 1) begin
                    n_fail++;
                    $display("FAIL rand%0d_nowrite: sets %0d end %0d want 0/%0d",
                             n, r_set_cycles, r_end_cycle, r_last_beat + 1);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic_refill();
        test_stall_hold();
        test_abort();
        test_bus_error();
        test_timeout();
        test_inval_during_refill();
        test_inval_idle();
        test_reset_mid_beat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
